// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-timing master for the 640x480@60 display path.
// Divides the system clock into a pixel enable, scans hCount/vCount, decodes
// the active area, and registers blanked colour plus syncs to the VGA pins so
// that colour and sync leave on the same pixel, one pixel behind the counters.
module vga_timing_gen #(
    parameter int DIV         = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int TICK_FRAMES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_tick,
    output logic        game_tick
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FC_W  = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(TICK_FRAMES - 1);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYN   = 10'(H_SYNC);
    localparam logic [9:0] V_SYN   = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_S = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_E = 10'(H_ACT_END);
    localparam logic [9:0] V_ACT_S = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_E = 10'(V_ACT_END);

    logic [DIV_W-1:0] div_cnt;
    logic [FC_W-1:0]  frame_cnt;
    logic             line_end;
    logic             frame_end;

    // Strobes are gated by rst so a reset landing on a pixel or frame boundary
    // never leaks a partial pulse.
    assign pix_en     = ~rst & (div_cnt == DIV_LAST);
    assign line_end   = (hCount == H_LAST);
    assign frame_end  = line_end & (vCount == V_LAST);
    assign frame_tick = pix_en & frame_end;
    assign game_tick  = frame_tick & (frame_cnt == FC_LAST);

    // Active-area decode seen by the renderers in the same cycle as the counters.
    assign bright = (hCount >= H_ACT_S) && (hCount < H_ACT_E) &&
                    (vCount >= V_ACT_S) && (vCount < V_ACT_E);

    // Clock divider: counts 0..DIV-1 and wraps; pix_en fires on the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster scan counters advance once per pixel period.
    always_ff @(posedge clk) begin
        if (rst) begin
            hCount <= 10'd0;
            vCount <= 10'd0;
        end else if (pix_en) begin
            if (line_end) begin
                hCount <= 10'd0;
                vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
            end else begin
                hCount <= hCount + 10'd1;
            end
        end
    end

    // Frame counter sets the game_tick cadence.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Pin register: blanked colour and syncs for the current pixel, held for DIV clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            hSync                 <= 1'b1;
            vSync                 <= 1'b1;
        end else if (pix_en) begin
            {vga_r, vga_g, vga_b} <= bright ? rgb_in : 12'h000;
            hSync                 <= ~(hCount < H_SYN);
            vSync                 <= ~(vCount < V_SYN);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a reduced raster so whole frames fit in
// a short run. The reference model derives every output from the number of
// clocks elapsed since reset release with plain division/modulo arithmetic.
module tb_vga_timing_gen;

    localparam int DIV   = 4;
    localparam int HT    = 32;
    localparam int HS    = 4;
    localparam int HA0   = 8;
    localparam int HA1   = 28;
    localparam int VT    = 16;
    localparam int VS    = 2;
    localparam int VA0   = 3;
    localparam int VA1   = 13;
    localparam int TF    = 3;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rgb_in = 12'h000;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic        hSync;
    logic        vSync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_tick;
    logic        game_tick;

    int checks = 0;
    int errors = 0;

    // Reference model state: clocks since reset release, and the expected pins.
    int          n = 0;
    logic [11:0] e_rgb = 12'h000;
    logic        e_hs = 1'b1;
    logic        e_vs = 1'b1;

    vga_timing_gen #(
        .DIV(DIV), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACT_END(VA1), .TICK_FRAMES(TF)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .pix_en(pix_en),
        .hCount(hCount), .vCount(vCount), .bright(bright),
        .hSync(hSync), .vSync(vSync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_tick(frame_tick), .game_tick(game_tick)
    );

    always #5 clk = ~clk;

    function automatic bit m_pix_en();
        return !rst && ((n % DIV) == DIV - 1);
    endfunction

    function automatic int m_h();
        return (n / DIV) % HT;
    endfunction

    function automatic int m_v();
        return ((n / DIV) / HT) % VT;
    endfunction

    function automatic bit m_bright();
        return (m_h() >= HA0) && (m_h() < HA1) && (m_v() >= VA0) && (m_v() < VA1);
    endfunction

    function automatic bit m_frame_tick();
        return m_pix_en() && (((n / DIV) + 1) % FRAME == 0);
    endfunction

    function automatic bit m_game_tick();
        return m_frame_tick() && ((((n / DIV) + 1) / FRAME) % TF == 0);
    endfunction

    // Advance the model across the coming edge, then move to #1 after it.
    task automatic step();
        if (rst) begin
            n     = 0;
            e_rgb = 12'h000;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
        end else begin
            if (m_pix_en()) begin
                e_rgb = m_bright() ? rgb_in : 12'h000;
                e_hs  = !(m_h() < HS);
                e_vs  = !(m_v() < VS);
            end
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({hCount, vCount} !== 20'h0) begin
            errors++; $display("FAIL reset_counters: got %0h expected 0", {hCount, vCount});
        end
        checks++;
        if ({hSync, vSync} !== 2'b11) begin
            errors++; $display("FAIL reset_syncs: got %b expected 11", {hSync, vSync});
        end
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            errors++; $display("FAIL reset_rgb: got %h expected 000", {vga_r, vga_g, vga_b});
        end
        checks++;
        if ({pix_en, frame_tick, game_tick} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000", {pix_en, frame_tick, game_tick});
        end
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (pix_en !== (c == 4)) begin
                errors++; $display("FAIL reset_first_pix_en clk %0d: got %b expected %b", c, pix_en, (c == 4));
            end
            step();
        end
        checks++;
        if (hCount !== 10'd1) begin
            errors++; $display("FAIL reset_hcount_after_first_pixel: got %0d expected 1", hCount);
        end
    endtask

    task automatic test_random_stream(input int cycles);
        logic [37:0] got;
        logic [37:0] exp;
        for (int c = 0; c < cycles; c++) begin
            rgb_in = 12'($urandom);
            got = {pix_en, hCount, vCount, bright, hSync, vSync, vga_r, vga_g, vga_b,
                   frame_tick, game_tick};
            exp = {m_pix_en(), 10'(m_h()), 10'(m_v()), m_bright(), e_hs, e_vs, e_rgb,
                   m_frame_tick(), m_game_tick()};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL stream n=%0d: got %h expected %h", n, got, exp);
            end
            step();
        end
    endtask

    task automatic test_line();
        int  fall;
        int  rise;
        bit  found;
        fall = -1;
        rise = -1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int t = 0; t < (HT + 2) * DIV; t++) begin
            if (fall < 0 && hSync === 1'b0) fall = t;
            else if (fall >= 0 && rise < 0 && hSync === 1'b1) rise = t;
            step();
        end
        checks++;
        if (fall != DIV) begin
            errors++; $display("FAIL hsync_start: got clk %0d expected clk %0d", fall, DIV);
        end
        checks++;
        if (rise - fall != HS * DIV) begin
            errors++; $display("FAIL hsync_width: got %0d clks expected %0d", rise - fall, HS * DIV);
        end
        found = 1'b0;
        for (int t = 0; t < (HT + 1) * DIV && !found; t++) begin
            if (pix_en === 1'b1 && hCount == 10'(HT - 1)) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL line_wrap: got timeout expected hCount %0d", HT - 1);
        end else begin
            step();
            if ({hCount, vCount} !== {10'd0, 10'd2}) begin
                errors++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,2)", hCount, vCount);
            end
        end
    endtask

    task automatic test_blanking();
        int          bh[6] = '{20, 7, 5, 20, 28, 27};
        int          bv[6] = '{2, 3, 8, 8, 8, 12};
        logic [11:0] bx[6] = '{12'h000, 12'h000, 12'h000, 12'hF0F, 12'h000, 12'hF0F};
        bit          found;
        rgb_in = 12'hF0F;
        for (int i = 0; i < 6; i++) begin
            found = 1'b0;
            for (int t = 0; t < 2 * FRAME * DIV && !found; t++) begin
                if (pix_en === 1'b1 && hCount == 10'(bh[i]) && vCount == 10'(bv[i])) found = 1'b1;
                else step();
            end
            step();
            checks++;
            if (!found || {vga_r, vga_g, vga_b} !== bx[i]) begin
                errors++;
                $display("FAIL blank (%0d,%0d): got %h found=%0d expected %h",
                         bh[i], bv[i], {vga_r, vga_g, vga_b}, found, bx[i]);
            end
        end
    endtask

    task automatic test_frame_wrap();
        bit found;
        int pix;
        int vlow;
        found = 1'b0;
        for (int t = 0; t < 2 * FRAME * DIV && !found; t++) begin
            if (frame_tick === 1'b1) found = 1'b1;
            else step();
        end
        checks++;
        if (!found || {hCount, vCount} !== {10'(HT - 1), 10'(VT - 1)}) begin
            errors++; $display("FAIL frame_tick_pos: got (%0d,%0d) found=%0d expected (%0d,%0d)",
                               hCount, vCount, found, HT - 1, VT - 1);
        end
        step();
        checks++;
        if (frame_tick !== 1'b0 || {hCount, vCount} !== 20'h0) begin
            errors++; $display("FAIL frame_wrap: got tick=%b (%0d,%0d) expected tick=0 (0,0)",
                               frame_tick, hCount, vCount);
        end
        pix = 0;
        vlow = 0;
        found = 1'b0;
        for (int t = 0; t < FRAME * DIV + DIV && !found; t++) begin
            if (pix_en === 1'b1) begin
                pix++;
                if (vSync === 1'b0) vlow++;
            end
            if (frame_tick === 1'b1) found = 1'b1;
            else step();
        end
        checks++;
        if (!found || pix != FRAME) begin
            errors++; $display("FAIL frame_period: got %0d pixels found=%0d expected %0d", pix, found, FRAME);
        end
        checks++;
        if (vlow != VS * HT) begin
            errors++; $display("FAIL vsync_width: got %0d pixels expected %0d", vlow, VS * HT);
        end
        step();
    endtask

    task automatic test_game_tick();
        int         ft;
        int         gclk;
        logic [7:0] gmask;
        ft = 0;
        gclk = 0;
        gmask = 8'h00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int t = 0; t < 7 * FRAME * DIV; t++) begin
            rgb_in = 12'($urandom);
            if (frame_tick === 1'b1) begin
                ft++;
                if (game_tick === 1'b1 && ft < 8) gmask[ft] = 1'b1;
            end
            if (game_tick === 1'b1) gclk++;
            step();
        end
        checks++;
        if (ft != 7) begin
            errors++; $display("FAIL frame_tick_count: got %0d expected 7", ft);
        end
        checks++;
        if (gmask !== 8'b0100_1000) begin
            errors++; $display("FAIL game_tick_frames: got %b expected 01001000", gmask);
        end
        checks++;
        if (gclk != 2) begin
            errors++; $display("FAIL game_tick_width: got %0d clks expected 2", gclk);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 2 * FRAME * DIV && !found; t++) begin
            rgb_in = 12'($urandom);
            if (pix_en === 1'b1 && hCount == 10'd20 && vCount == 10'd10) found = 1'b1;
            else step();
        end
        rgb_in = 12'hF0F;
        step();
        checks++;
        if (!found || {vga_r, vga_g, vga_b} !== 12'hF0F) begin
            errors++; $display("FAIL midrst_pre: got %h found=%0d expected f0f", {vga_r, vga_g, vga_b}, found);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({hCount, vCount, hSync, vSync, vga_r, vga_g, vga_b, frame_tick, pix_en} !==
            {20'h0, 2'b11, 12'h000, 2'b00}) begin
            errors++; $display("FAIL midrst_state: got (%0d,%0d) hs=%b vs=%b rgb=%h ft=%b pe=%b expected (0,0) 1 1 000 0 0",
                               hCount, vCount, hSync, vSync, {vga_r, vga_g, vga_b}, frame_tick, pix_en);
        end
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (pix_en !== (c == 4)) begin
                errors++; $display("FAIL midrst_pix_en clk %0d: got %b expected %b", c, pix_en, (c == 4));
            end
            step();
        end
        checks++;
        if (hCount !== 10'd1) begin
            errors++; $display("FAIL midrst_hcount: got %0d expected 1", hCount);
        end
        // Reset landing exactly on the frame-end pixel must suppress the ticks.
        found = 1'b0;
        for (int t = 0; t < FRAME * DIV + DIV && !found; t++) begin
            if (pix_en === 1'b1 && hCount == 10'(HT - 1) && vCount == 10'(VT - 1)) found = 1'b1;
            else step();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!found || {frame_tick, game_tick, pix_en} !== 3'b000) begin
            errors++; $display("FAIL rst_on_frame_end: got %b found=%0d expected 000",
                               {frame_tick, game_tick, pix_en}, found);
        end
        step();
        rst = 1'b0;
        checks++;
        if ({hCount, vCount, frame_tick} !== 21'h0) begin
            errors++; $display("FAIL rst_on_frame_end_after: got (%0d,%0d) ft=%b expected (0,0) 0",
                               hCount, vCount, frame_tick);
        end
    endtask

    initial begin
        rst = 1'b1;
        rgb_in = 12'h000;
        step();
        step();
        test_reset();
        test_random_stream(2 * FRAME * DIV + 300);
        test_line();
        test_blanking();
        test_frame_wrap();
        test_game_tick();
        test_mid_reset();
        test_random_stream(1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel-timing master for the 640x480@60 display path. It divides the 100 MHz system clock into a 25 MHz pixel enable and produces hCount, vCount and bright for the combinational renderers. It samples the renderer's 12-bit rgb, blanks it outside the active area, and registers it to the VGA pins with hSync/vSync on the same pixel. It also produces frame_tick and a game_tick that drives game-state updates.

Parameters:
DIV, 4, system clocks per pixel; must be ≥2.
H_TOTAL, 800, pixels per line.
H_SYNC, 96, hSync low for hCount 0..H_SYNC-1.
H_ACT_START, 144, first active hCount.
H_ACT_END, 784, first inactive hCount after the active area.
V_TOTAL, 525, lines per frame.
V_SYNC, 2, vSync low for vCount 0..V_SYNC-1.
V_ACT_START, 35, first active vCount.
V_ACT_END, 515, first inactive vCount after the active area.
TICK_FRAMES, 1, frames per game_tick; must be ≥1.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
rgb_in  in  12  renderer colour for the current hCount/vCount, {R,G,B} 4 bits each
pix_en  out  1  one-clk strobe, one per pixel period
hCount  out  10  current pixel column, 0..H_TOTAL-1
vCount  out  10  current line, 0..V_TOTAL-1
bright  out  1  combinational: hCount in [H_ACT_START,H_ACT_END) and vCount in [V_ACT_START,V_ACT_END)
hSync  out  1  registered, active-low
vSync  out  1  registered, active-low
vga_r  out  4  registered red
vga_g  out  4  registered green
vga_b  out  4  registered blue
frame_tick  out  1  one-clk pulse at frame wrap
game_tick  out  1  one-clk pulse every TICK_FRAMES frames

Behaviour:
- Reset: one clock, synchronous, active-high. On rst, all state loads in that cycle:
  - div_cnt=0, hCount=0, vCount=0, frame counter=0.
  - hSync=1, vSync=1, vga_r/g/b=0, frame_tick=0, game_tick=0, pix_en=0.
- Reset asserted mid-frame overrides everything in that cycle. The frame restarts at (0,0) on the first pixel after release, with no partial pulses.
- Divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - pix_en=1 exactly in the cycle where div_cnt==DIV-1, i.e. every DIV clocks. The first pix_en is DIV clocks after rst deasserts.
- Counters: change only on a pix_en cycle, taking effect the following clk.
  - hCount==H_TOTAL-1: hCount→0 and vCount increments.
  - vCount==V_TOTAL-1 at the same time: vCount→0.
  - Otherwise hCount increments.
  - hCount/vCount stay stable for the DIV clocks of each pixel.
- bright: pure decode of the current counters; renderers see hCount, vCount and bright in the same cycle.
- Output register, updated only on pix_en cycles and held otherwise:
  - {vga_r,vga_g,vga_b} <= bright ? rgb_in : 12'h000.
  - hSync <= ~(hCount < H_SYNC).
  - vSync <= ~(vCount < V_SYNC).
- Output latency: pins lag the counters by exactly one pixel (DIV clocks). Sync and colour are mutually aligned.
- rgb_in: sampled only in the pix_en cycle; its value at any other time is ignored.
- frame_tick: 1 for exactly one clk, in the pix_en cycle where hCount==H_TOTAL-1 and vCount==V_TOTAL-1.
- game_tick:
  - The frame counter increments on each frame_tick and wraps at TICK_FRAMES-1→0.
  - game_tick = frame_tick AND (frame counter==TICK_FRAMES-1).
  - With TICK_FRAMES=1, game_tick equals frame_tick.
- Widths: counters are 10-bit unsigned. All comparisons are unsigned, against parameters sized to 10 bits.

Test Plan:
1. Reset: hold rst 3 clks → hCount=0, vCount=0, hSync=1, vSync=1, vga=000, ticks 0. Release → pix_en first high on clk 4; hCount=1 after it.
2. Line timing (DIV=4), 1 line captured:
   - hSync low for exactly 96 pixels (384 clks), starting one pixel after hCount=0.
   - At hCount 799→0, vCount increments 0→1.
3. Blanking: rgb_in held 12'hF0F.
   - Counter pixel (100,100) → pins 000 one pixel later.
   - Pixel (200,100) → pins F0F.
   - Pixel (784,100) → 000.
   - Pixel (200,20) → 000.
4. Frame wrap:
   - At (799,524): frame_tick is exactly 1 clk wide, then counters are (0,0).
   - vSync low for exactly 2 lines (1600 pixels).
   - Exactly 420000 pixels between consecutive frame_ticks.
5. game_tick with TICK_FRAMES=3: over 7 frames, game_tick fires on frame_ticks 3 and 6 only, each 1 clk wide.
6. Mid-frame reset:
   - At (400,300), with vga=F0F, assert rst for 1 clk.
   - Next cycle: counters 0, hSync=vSync=1, vga=000, no frame_tick.
   - Timing then matches scenario 1.
